// File: rtl/lcd_bus_reader_pkg.sv
// rtl/lcd_bus_reader_pkg.sv - shared LCD bus addresses, read FSM encoding and default timing
package lcd_bus_reader_pkg;

  // Host command addresses; the write path decodes 2/3 as data/command writes.
  localparam logic [2:0] ADDR_DATA_WR   = 3'd2;
  localparam logic [2:0] ADDR_CMD_WR    = 3'd3;
  localparam logic [2:0] ADDR_DATA_RD   = 3'd2;
  localparam logic [2:0] ADDR_STAT_RD   = 3'd3;
  localparam logic [2:0] ADDR_STAT_POLL = 3'd4;

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_SETUP   = 3'd1;
  localparam logic [2:0] ST_STROBE  = 3'd2;
  localparam logic [2:0] ST_HOLD    = 3'd3;
  localparam logic [2:0] ST_RECOVER = 3'd4;

  typedef enum logic [1:0] {MODE_DATA, MODE_STAT, MODE_POLL} rdMode_t;

  localparam int DEF_SETUP_CYC    = 1;
  localparam int DEF_RD_LOW_CYC   = 4;
  localparam int DEF_HOLD_CYC     = 2;
  localparam int DEF_RECOVERY_CYC = 2;
  localparam int DEF_POLL_LIMIT   = 255;

  function automatic int maxCycles(input int a, input int b, input int c, input int d);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    return m;
  endfunction

endpackage

// File: rtl/lcd_bus_reader_phase_timer.sv
// rtl/lcd_bus_reader_phase_timer.sv - loadable down-counter with terminal-count flag
module lcd_phase_timer #(
  parameter int W = 3
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] loadVal,
  output logic         tc
);

  logic [W-1:0] count;

  always_ff @(posedge clk) begin
    if (rst)
      count <= '0;
    else if (load)
      count <= loadVal;
    else if (count != '0)
      count <= count - 1'b1;
  end

  assign tc = (count == '0);

endmodule

// File: rtl/lcd_bus_reader.sv
// rtl/lcd_bus_reader.sv - 8080-style LCD read engine: data read, status read, busy polling
module lcd_bus_reader
  import lcd_bus_reader_pkg::*;
#(
  parameter int DATA_W       = 8,
  parameter int ADDR_W       = 3,
  parameter int SETUP_CYC    = DEF_SETUP_CYC,
  parameter int RD_LOW_CYC   = DEF_RD_LOW_CYC,
  parameter int HOLD_CYC     = DEF_HOLD_CYC,
  parameter int RECOVERY_CYC = DEF_RECOVERY_CYC,
  parameter int POLL_LIMIT   = DEF_POLL_LIMIT,
  parameter int BUSY_BIT     = 7
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rdReq,
  input  logic [ADDR_W-1:0] commAddr,
  output logic              rdBusy,
  output logic [DATA_W-1:0] rdData,
  output logic              rdValid,
  output logic              rdTimeout,
  input  logic [7:0]        lcdDataIn,
  output logic              lcdRs,
  output logic              lcdRd,
  output logic              lcdWr,
  output logic              lcdCs
);

  localparam int CNT_W = $clog2(maxCycles(SETUP_CYC, RD_LOW_CYC, HOLD_CYC, RECOVERY_CYC) + 1);

  logic [2:0]       state;
  rdMode_t          mode;
  logic [7:0]       sample;
  logic [7:0]       pollCount;
  logic [8:0]       pollNext;
  logic             isData, isStat, isPoll, accept, repoll;
  logic             timLoad, tc;
  logic [CNT_W-1:0] timVal;

  assign isData   = (commAddr == ADDR_W'(ADDR_DATA_RD));
  assign isStat   = (commAddr == ADDR_W'(ADDR_STAT_RD));
  assign isPoll   = (commAddr == ADDR_W'(ADDR_STAT_POLL));
  assign accept   = rdReq && (isData || isStat || isPoll);
  assign pollNext = {1'b0, pollCount} + 9'd1;
  assign repoll   = (mode == MODE_POLL) && sample[BUSY_BIT] && (pollNext < 9'(POLL_LIMIT));
  assign lcdWr    = 1'b1;

  // The timer is reloaded on exactly the edges where the FSM changes phase.
  always_comb begin
    timLoad = 1'b0;
    timVal  = '0;
    case (state)
      ST_IDLE:    if (accept)        begin timLoad = 1'b1; timVal = CNT_W'(SETUP_CYC - 1);    end
      ST_SETUP:   if (tc)            begin timLoad = 1'b1; timVal = CNT_W'(RD_LOW_CYC - 1);   end
      ST_STROBE:  if (tc)            begin timLoad = 1'b1; timVal = CNT_W'(HOLD_CYC - 1);     end
      ST_HOLD:    if (tc)            begin timLoad = 1'b1; timVal = CNT_W'(RECOVERY_CYC - 1); end
      ST_RECOVER: if (tc && repoll)  begin timLoad = 1'b1; timVal = CNT_W'(SETUP_CYC - 1);    end
      default: ;
    endcase
  end

  lcd_phase_timer #(.W(CNT_W)) phaseTimer (
    .clk     (clk),
    .rst     (rst),
    .load    (timLoad),
    .loadVal (timVal),
    .tc      (tc)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      mode      <= MODE_DATA;
      sample    <= '0;
      pollCount <= '0;
      rdBusy    <= 1'b0;
      rdData    <= '0;
      rdValid   <= 1'b0;
      rdTimeout <= 1'b0;
      lcdRs     <= 1'b1;
      lcdRd     <= 1'b1;
      lcdCs     <= 1'b1;
    end else begin
      rdValid   <= 1'b0;
      rdTimeout <= 1'b0;
      case (state)
        ST_IDLE: if (accept) begin
          mode      <= isData ? MODE_DATA : (isStat ? MODE_STAT : MODE_POLL);
          lcdRs     <= isData;
          pollCount <= '0;
          rdBusy    <= 1'b1;
          lcdCs     <= 1'b0;
          state     <= ST_SETUP;
        end
        ST_SETUP: if (tc) begin
          lcdRd <= 1'b0;
          state <= ST_STROBE;
        end
        // Capture on the last edge of the strobe, while RD is still low.
        ST_STROBE: if (tc) begin
          sample <= lcdDataIn;
          lcdRd  <= 1'b1;
          state  <= ST_HOLD;
        end
        ST_HOLD: if (tc) begin
          lcdCs <= 1'b1;
          state <= ST_RECOVER;
        end
        ST_RECOVER: if (tc) begin
          if (repoll) begin
            pollCount <= pollNext[7:0];
            lcdCs     <= 1'b0;
            state     <= ST_SETUP;
          end else begin
            rdData    <= DATA_W'(sample);
            rdValid   <= 1'b1;
            rdTimeout <= (mode == MODE_POLL) && sample[BUSY_BIT];
            rdBusy    <= 1'b0;
            state     <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lcd_bus_reader.sv
// tb/tb_lcd_bus_reader.sv - scoreboard bench for lcd_bus_reader
module tb_lcd_bus_reader;

  typedef struct {
    logic [7:0] data;
    logic       to;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       rdReq, rdReq2;
  logic [2:0] commAddr, commAddr2;
  logic       rdBusy, rdValid, rdTimeout, lcdRs, lcdRd, lcdWr, lcdCs;
  logic [7:0] rdData;
  logic [7:0] lcdDataIn = 8'h00;
  logic       rdBusy2, rdValid2, rdTimeout2, lcdRs2, lcdRd2, lcdWr2, lcdCs2;
  logic [7:0] rdData2;
  logic [7:0] lcdDataIn2;

  exp_t       q1[$], q2[$];
  exp_t       e1, e2;
  logic [7:0] respQ[$];
  int         errors = 0, checks = 0;
  int         validCnt = 0, validCnt2 = 0;
  int         rdPulses = 0, csPulses = 0, rdPulses2 = 0;
  int         rsHighCnt = 0, rsLowCnt = 0;

  always #5 clk = ~clk;

  lcd_bus_reader dut (
    .clk(clk), .rst(rst), .rdReq(rdReq), .commAddr(commAddr),
    .rdBusy(rdBusy), .rdData(rdData), .rdValid(rdValid), .rdTimeout(rdTimeout),
    .lcdDataIn(lcdDataIn), .lcdRs(lcdRs), .lcdRd(lcdRd), .lcdWr(lcdWr), .lcdCs(lcdCs)
  );

  lcd_bus_reader #(.POLL_LIMIT(3)) dut2 (
    .clk(clk), .rst(rst), .rdReq(rdReq2), .commAddr(commAddr2),
    .rdBusy(rdBusy2), .rdData(rdData2), .rdValid(rdValid2), .rdTimeout(rdTimeout2),
    .lcdDataIn(lcdDataIn2), .lcdRs(lcdRs2), .lcdRd(lcdRd2), .lcdWr(lcdWr2), .lcdCs(lcdCs2)
  );

  assign lcdDataIn2 = 8'h80;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Panel model: each falling RD presents the next queued byte, otherwise holds.
  always @(negedge lcdRd) begin
    rdPulses++;
    if (respQ.size() > 0) lcdDataIn = respQ.pop_front();
  end
  always @(negedge lcdCs)  csPulses++;
  always @(negedge lcdRd2) rdPulses2++;

  always @(negedge clk) begin
    if (lcdCs === 1'b0) begin
      if (lcdRs) rsHighCnt++;
      else       rsLowCnt++;
    end
    if (rdValid === 1'b1) begin
      validCnt++;
      if (q1.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected rdValid: got data %0h expected no response", rdData);
      end else begin
        e1 = q1.pop_front();
        check("rdData", 32'(rdData), 32'(e1.data));
        check("rdTimeout", 32'(rdTimeout), 32'(e1.to));
        check("rdBusy in valid cycle", 32'(rdBusy), 32'd0);
      end
    end
    if (rdValid2 === 1'b1) begin
      validCnt2++;
      if (q2.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected rdValid2: got data %0h expected no response", rdData2);
      end else begin
        e2 = q2.pop_front();
        check("rdData2", 32'(rdData2), 32'(e2.data));
        check("rdTimeout2", 32'(rdTimeout2), 32'(e2.to));
      end
    end
  end

  task automatic waitValid(input int startV, input string name);
    int i;
    i = 0;
    while (validCnt == startV && i < 2000) begin
      @(negedge clk);
      i++;
    end
    check({name, " completes"}, 32'(validCnt != startV), 32'd1);
  endtask

  task automatic runRead(input string name, input logic [2:0] a, input logic [7:0] d,
                         input logic to, input int pulses, input logic expRs);
    int startV, startRd, startCs, startHi, startLo;
    startV = validCnt; startRd = rdPulses; startCs = csPulses;
    startHi = rsHighCnt; startLo = rsLowCnt;
    @(negedge clk);
    rdReq = 1'b1; commAddr = a;
    q1.push_back('{d, to});
    @(negedge clk);
    rdReq = 1'b0;
    waitValid(startV, name);
    repeat (3) @(negedge clk);
    check({name, " rd pulses"}, 32'(rdPulses - startRd), 32'(pulses));
    check({name, " cs pulses"}, 32'(csPulses - startCs), 32'(pulses));
    check({name, " rs wrong cycles"},
          32'(expRs ? (rsLowCnt - startLo) : (rsHighCnt - startHi)), 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1);
  end

  initial begin
    logic [10:0] csMask, rdMask, vMask;
    int          sv, sr, sc, sv2, sr2, i;
    rst = 1'b1; rdReq = 1'b0; commAddr = 3'd0; rdReq2 = 1'b0; commAddr2 = 3'd0;
    repeat (3) @(negedge clk);
    check("reset rdBusy", 32'(rdBusy), 32'd0);
    check("reset rdData", 32'(rdData), 32'd0);
    check("reset rdValid", 32'(rdValid), 32'd0);
    check("reset rdTimeout", 32'(rdTimeout), 32'd0);
    check("reset lcdRs", 32'(lcdRs), 32'd1);
    check("reset lcdRd", 32'(lcdRd), 32'd1);
    check("reset lcdCs", 32'(lcdCs), 32'd1);
    check("reset lcdWr", 32'(lcdWr), 32'd1);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Data read latency profile relative to the accept edge.
    respQ.push_back(8'hA5);
    sv = validCnt; sr = rdPulses; sc = rsLowCnt;
    csMask = '0; rdMask = '0; vMask = '0;
    rdReq = 1'b1; commAddr = 3'd2;
    q1.push_back('{8'hA5, 1'b0});
    @(posedge clk);
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      rdReq = 1'b0;
      csMask[k] = ~lcdCs;
      rdMask[k] = ~lcdRd;
      vMask[k]  = rdValid;
    end
    @(negedge clk);
    check("data cs low cycles", 32'(csMask), 32'h0FE);
    check("data rd low cycles", 32'(rdMask), 32'h03C);
    check("data valid cycle", 32'(vMask), 32'h400);
    check("data valid count", 32'(validCnt - sv), 32'd1);
    check("data rd pulses", 32'(rdPulses - sr), 32'd1);
    check("data rs low cycles", 32'(rsLowCnt - sc), 32'd0);

    respQ.push_back(8'h3C);
    runRead("status", 3'd3, 8'h3C, 1'b0, 1, 1'b0);

    respQ.push_back(8'h80); respQ.push_back(8'h80);
    respQ.push_back(8'h80); respQ.push_back(8'h01);
    runRead("poll", 3'd4, 8'h01, 1'b0, 4, 1'b0);

    // Poll against a panel stuck busy with a limit of three reads.
    sv2 = validCnt2; sr2 = rdPulses2;
    @(negedge clk);
    rdReq2 = 1'b1; commAddr2 = 3'd4;
    q2.push_back('{8'h80, 1'b1});
    @(negedge clk);
    rdReq2 = 1'b0;
    i = 0;
    while (validCnt2 == sv2 && i < 2000) begin
      @(negedge clk);
      i++;
    end
    check("timeout poll completes", 32'(validCnt2 - sv2), 32'd1);
    check("timeout poll rd pulses", 32'(rdPulses2 - sr2), 32'd3);

    // Reset during the second strobe cycle aborts the read silently.
    respQ.push_back(8'h77);
    sv = validCnt;
    @(negedge clk);
    rdReq = 1'b1; commAddr = 3'd2;
    @(posedge clk);
    @(negedge clk);
    rdReq = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("pre-reset lcdRd low", 32'(lcdRd), 32'd0);
    rst = 1'b1;
    @(negedge clk);
    check("abort lcdRd", 32'(lcdRd), 32'd1);
    check("abort lcdCs", 32'(lcdCs), 32'd1);
    check("abort rdBusy", 32'(rdBusy), 32'd0);
    check("abort rdData", 32'(rdData), 32'd0);
    rst = 1'b0;
    repeat (15) @(negedge clk);
    check("abort no valid", 32'(validCnt - sv), 32'd0);
    respQ.push_back(8'h5A);
    runRead("after reset", 3'd2, 8'h5A, 1'b0, 1, 1'b1);

    // Unsupported address is dropped.
    sv = validCnt; sr = rdPulses; sc = csPulses;
    @(negedge clk);
    rdReq = 1'b1; commAddr = 3'd5;
    @(negedge clk);
    rdReq = 1'b0;
    repeat (15) @(negedge clk);
    check("addr5 rd pulses", 32'(rdPulses - sr), 32'd0);
    check("addr5 cs pulses", 32'(csPulses - sc), 32'd0);
    check("addr5 no valid", 32'(validCnt - sv), 32'd0);

    // A request pulsed mid-strobe must not disturb the in-flight data read.
    respQ.push_back(8'hC3);
    sv = validCnt; sr = rdPulses; sc = rsLowCnt;
    @(negedge clk);
    rdReq = 1'b1; commAddr = 3'd2;
    q1.push_back('{8'hC3, 1'b0});
    @(negedge clk);
    rdReq = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rdReq = 1'b1; commAddr = 3'd3;
    @(negedge clk);
    rdReq = 1'b0;
    waitValid(sv, "inflight");
    repeat (15) @(negedge clk);
    check("inflight single valid", 32'(validCnt - sv), 32'd1);
    check("inflight rd pulses", 32'(rdPulses - sr), 32'd1);
    check("inflight rs low cycles", 32'(rsLowCnt - sc), 32'd0);
    check("scoreboard drained", 32'(q1.size() + q2.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
